// File: rtl/pr_dec_strobe.sv
// Registered 3-to-8 decoder that turns an accepted code into a timed one-hot strobe,
// followed by an enforced idle gap before the next code is taken.
module pr_dec_strobe #(
  parameter int unsigned PULSE_LEN = 4,
  parameter int unsigned GAP_LEN   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       cancel,
  output logic [7:0] d,
  output logic       d_valid,
  output logic       busy,
  output logic [7:0] strobe_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [3:0] PULSE_LOAD = 4'(PULSE_LEN - 1);
  localparam logic [3:0] GAP_LOAD   = (GAP_LEN > 0) ? 4'(GAP_LEN - 1) : 4'd0;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] code_q, code_d;
  logic [7:0] strobe_cnt_q, strobe_cnt_d;
  logic [7:0] d_q, d_d;
  logic       d_valid_q, d_valid_d;
  logic       in_ready_q, in_ready_d;
  logic       busy_q, busy_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    code_d       = code_q;
    strobe_cnt_d = strobe_cnt_q;

    case (state_q)
      IDLE: begin
        // The code is only sampled on an accepting edge, so don't-care
        // inputs at any other time cannot reach d.
        if (in_valid) begin
          state_d = PULSE;
          cnt_d   = PULSE_LOAD;
          code_d  = {a, b, c};
        end
      end
      PULSE: begin
        if (cancel) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          strobe_cnt_d = strobe_cnt_q + 8'd1;
          if (GAP_LEN > 0) begin
            state_d = GAP;
            cnt_d   = GAP_LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      GAP: begin
        if (cancel || cnt_q == 4'd0) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    d_valid_d  = (state_d == PULSE);
    d_d        = d_valid_d ? (8'b1 << code_d) : 8'h00;
    in_ready_d = (state_d == IDLE);
    busy_d     = ~in_ready_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      code_q       <= 3'b000;
      strobe_cnt_q <= 8'h00;
      d_q          <= 8'h00;
      d_valid_q    <= 1'b0;
      in_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      code_q       <= code_d;
      strobe_cnt_q <= strobe_cnt_d;
      d_q          <= d_d;
      d_valid_q    <= d_valid_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
    end
  end

  assign d          = d_q;
  assign d_valid    = d_valid_q;
  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign strobe_cnt = strobe_cnt_q;

endmodule
